// File: rtl/mpeg_audio_pacer.sv
// MPEG audio pacer: fractional-rate sample pump from a FIFO into a
// left/right output pair, with prefill, underrun recovery and mute.
module mpeg_audio_pacer #(
  parameter logic [31:0] PHASE_INC = 32'd147,
  parameter logic [31:0] PHASE_MOD = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mute,
  input  logic        fifo_valid,
  input  logic [15:0] fifo_sample,
  input  logic        fifo_half_full,
  output logic        fifo_strobe,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        frame_strobe,
  output logic        playing,
  output logic [15:0] underrun_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREFILL  = 2'd1;
  localparam logic [1:0] S_PLAY     = 2'd2;
  localparam logic [1:0] S_UNDERRUN = 2'd3;

  logic [1:0]  state;
  logic [31:0] acc;
  logic [32:0] acc_sum;
  logic        tick;
  logic        lr;
  logic [15:0] left_buf;
  logic [15:0] sample_w;

  assign acc_sum = {1'b0, acc} + {1'b0, PHASE_INC};
  assign tick = enable && (acc_sum >= {1'b0, PHASE_MOD});

  assign fifo_strobe = !reset && enable && (state == S_PLAY)
                    && tick && fifo_valid;
  assign playing  = (state == S_PLAY);
  assign sample_w = mute ? 16'h0000 : fifo_sample;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      acc <= '0;
    end else if (tick) begin
      acc <= 32'(acc_sum - {1'b0, PHASE_MOD});
    end else begin
      acc <= acc_sum[31:0];
    end
  end

  // Left is staged so the outputs only ever change as a complete pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      lr             <= 1'b0;
      left_buf       <= '0;
      left           <= '0;
      right          <= '0;
      frame_strobe   <= 1'b0;
      underrun_count <= '0;
    end else if (!enable) begin
      state        <= S_IDLE;
      lr           <= 1'b0;
      left_buf     <= '0;
      left         <= '0;
      right        <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state <= S_PREFILL;
          lr    <= 1'b0;
        end
        S_PREFILL: begin
          if (fifo_half_full) state <= S_PLAY;
        end
        S_PLAY: begin
          if (tick && fifo_valid) begin
            lr <= ~lr;
            if (!lr) begin
              left_buf <= sample_w;
            end else begin
              left         <= left_buf;
              right        <= sample_w;
              frame_strobe <= 1'b1;
            end
          end else if (tick) begin
            state    <= S_UNDERRUN;
            left     <= '0;
            right    <= '0;
            left_buf <= '0;
            if (underrun_count != 16'hFFFF)
              underrun_count <= underrun_count + 16'd1;
          end
        end
        S_UNDERRUN: begin
          if (fifo_half_full) begin
            state <= S_PLAY;
            lr    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
